// File: rtl/up_pkg.sv
// Shared definitions for the serial programming transmitter: sync byte,
// FSM state encoding and the 8N1 frame builder.
package up_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'h55;

  typedef enum logic [2:0] {
    UP_TX_IDLE,
    UP_TX_FRAME,
    UP_TX_GAP,
    UP_TX_FETCH,
    UP_TX_CAPT
  } up_tx_state_e;

  // Frame bits in transmit order from bit 0: start(0), data LSB..MSB, stop(1).
  function automatic logic [9:0] up_frame(input logic [7:0] b);
    return {1'b1, b, 1'b0};
  endfunction

endpackage

// File: rtl/up_prog_tx_if.sv
// Host-side bundle of the programming transmitter: control handshake,
// image memory read port and the target-facing pins.
interface up_prog_tx_if;

  logic       start;
  logic [7:0] length;
  logic       mem_rd;
  logic [7:0] mem_addr;
  logic [7:0] mem_data;
  logic       prog;
  logic       tx;
  logic       busy;
  logic       done;

  modport master (
    output start, length, mem_data,
    input  mem_rd, mem_addr, prog, tx, busy, done
  );

  modport slave (
    input  start, length, mem_data,
    output mem_rd, mem_addr, prog, tx, busy, done
  );

endinterface

// File: rtl/up_baud_tick.sv
// Bit-period timer: CLK_DIV-cycle down-counter with synchronous restart,
// ticking on the last cycle of every bit period.
module up_baud_tick #(
  parameter int CLK_DIV = 434
) (
  input  logic clk,
  input  logic nRst,
  input  logic restart,
  output logic tick
);

  localparam int            DW     = $clog2(CLK_DIV);
  localparam logic [DW-1:0] RELOAD = DW'(CLK_DIV - 1);

  logic [DW-1:0] cnt;

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst)                cnt <= RELOAD;
    else if (restart || tick) cnt <= RELOAD;
    else                      cnt <= cnt - DW'(1);
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/up_prog_tx.sv
// Serial program downloader: raises prog, sends the autobaud sync byte, then
// streams the image memory as 8N1 frames separated by idle-high gaps.
//
//   state | meaning
//   IDLE  | waiting for start; prog/busy low, tx high
//   FRAME | shifting out start, 8 data, stop bits
//   GAP   | GAP_BITS idle-high bit times after the stop bit
//   FETCH | mem_rd strobe for the next image byte
//   CAPT  | load read data into the frame shifter
module up_prog_tx
  import up_pkg::*;
#(
  parameter int CLK_DIV  = 434,
  parameter int GAP_BITS = 2
) (
  input logic         clk,
  input logic         nRst,
  up_prog_tx_if.slave bus
);

  localparam int            GW       = (GAP_BITS > 1) ? $clog2(GAP_BITS) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);

  up_tx_state_e  state, state_nxt;
  logic [9:0]    shifter;
  logic [3:0]    bit_idx;
  logic [GW-1:0] gap_cnt;
  logic [8:0]    byte_cnt;
  logic [8:0]    len_q;
  logic          tick;
  logic          restart;
  logic          frame_end;
  logic          gap_end;
  logic          last;
  logic          finish;

  // Timer free-runs only while a bit period is being timed.
  assign restart   = !(state == UP_TX_FRAME || state == UP_TX_GAP);
  assign frame_end = (state == UP_TX_FRAME) && tick && (bit_idx == 4'd9);
  assign gap_end   = (state == UP_TX_GAP) && tick && (gap_cnt == GAP_LAST);
  assign last      = (byte_cnt == len_q);
  assign finish    = last && (gap_end || (frame_end && GAP_BITS == 0));

  up_baud_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .nRst    (nRst),
    .restart (restart),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) state <= UP_TX_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      UP_TX_IDLE:  if (bus.start) state_nxt = UP_TX_FRAME;
      UP_TX_FRAME: begin
        if (frame_end) begin
          if (GAP_BITS == 0) state_nxt = last ? UP_TX_IDLE : UP_TX_FETCH;
          else               state_nxt = UP_TX_GAP;
        end
      end
      UP_TX_GAP:   if (gap_end) state_nxt = last ? UP_TX_IDLE : UP_TX_FETCH;
      UP_TX_FETCH: state_nxt = UP_TX_CAPT;
      UP_TX_CAPT:  state_nxt = UP_TX_FRAME;
      default:     state_nxt = UP_TX_IDLE;
    endcase
  end

  always_comb begin
    bus.tx     = 1'b1;
    bus.mem_rd = 1'b0;
    bus.prog   = 1'b1;
    bus.busy   = 1'b1;
    unique case (state)
      UP_TX_IDLE: begin
        bus.prog = 1'b0;
        bus.busy = 1'b0;
      end
      UP_TX_FRAME: bus.tx     = shifter[0];
      UP_TX_FETCH: bus.mem_rd = 1'b1;
      default: ;
    endcase
  end

  assign bus.mem_addr = byte_cnt[7:0];

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      shifter  <= '1;
      bit_idx  <= '0;
      gap_cnt  <= '0;
      byte_cnt <= '0;
      len_q    <= '0;
      bus.done <= 1'b0;
    end else begin
      bus.done <= finish;
      unique case (state)
        UP_TX_IDLE: begin
          if (bus.start) begin
            len_q    <= (bus.length == 8'd0) ? 9'd256 : {1'b0, bus.length};
            shifter  <= up_frame(SYNC_BYTE);
            bit_idx  <= '0;
            byte_cnt <= '0;
          end
        end
        UP_TX_FRAME: begin
          if (tick) begin
            shifter <= {1'b1, shifter[9:1]};
            bit_idx <= (bit_idx == 4'd9) ? 4'd0 : bit_idx + 4'd1;
            gap_cnt <= '0;
          end
        end
        UP_TX_GAP: if (tick) gap_cnt <= gap_cnt + GW'(1);
        UP_TX_CAPT: begin
          shifter  <= up_frame(bus.mem_data);
          bit_idx  <= '0;
          byte_cnt <= byte_cnt + 9'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_up_prog_tx.sv
// Bench for up_prog_tx: cycle-exact trace model built from the frame/gap/fetch
// schedule, a UART receiver + loader model, and directed download scenarios.
module tb_up_prog_tx;

  localparam int D = 4;

  logic clk = 1'b0;
  logic nRst;

  up_prog_tx_if bus_a ();
  up_prog_tx_if bus_b ();

  up_prog_tx #(.CLK_DIV(D), .GAP_BITS(2)) dut_a (.clk(clk), .nRst(nRst), .bus(bus_a));
  up_prog_tx #(.CLK_DIV(D), .GAP_BITS(0)) dut_b (.clk(clk), .nRst(nRst), .bus(bus_b));

  always #5 clk = ~clk;

  logic [7:0] mem [256];

  always @(posedge clk) begin
    if (bus_a.mem_rd) bus_a.mem_data <= mem[bus_a.mem_addr];
    if (bus_b.mem_rd) bus_b.mem_data <= mem[bus_b.mem_addr];
  end

  typedef struct packed {
    logic       tx;
    logic       prog;
    logic       busy;
    logic       done;
    logic       rd;
    logic [7:0] addr;
  } exp_t;

  localparam exp_t IDLE_E = exp_t'{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

  exp_t qa[$];
  exp_t qb[$];
  exp_t cur_a = IDLE_E;
  exp_t cur_b = IDLE_E;
  int   total = 0;
  int   bad   = 0;

  function automatic void cmp(string nm, int act, int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s at t=%0t: got 0x%0h, want 0x%0h", nm, $time, act, want);
    end
  endfunction

  function automatic void push(int which, exp_t e);
    if (which == 0) qa.push_back(e);
    else            qb.push_back(e);
  endfunction

  // Expected per-cycle outputs for a whole download of n image bytes.
  function automatic void build(int which, int gap, int n);
    logic [9:0] fr;
    logic [7:0] b;
    for (int j = 0; j <= n; j++) begin
      b  = (j == 0) ? 8'h55 : mem[j-1];
      fr = {1'b1, b, 1'b0};
      for (int k = 0; k < 10; k++)
        for (int c = 0; c < D; c++)
          push(which, exp_t'{fr[k], 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
      for (int c = 0; c < gap * D; c++)
        push(which, exp_t'{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
      if (j < n) begin
        push(which, exp_t'{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'(j)});
        push(which, exp_t'{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00});
      end
    end
    push(which, exp_t'{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00});
  endfunction

  initial forever begin
    @(posedge clk or negedge nRst);
    if (!nRst) begin
      qa.delete();
      qb.delete();
      cur_a = IDLE_E;
      cur_b = IDLE_E;
    end else begin
      if (!cur_a.busy && bus_a.start)
        build(0, 2, (bus_a.length == 8'd0) ? 256 : int'(bus_a.length));
      if (!cur_b.busy && bus_b.start)
        build(1, 0, (bus_b.length == 8'd0) ? 256 : int'(bus_b.length));
      cur_a = (qa.size() > 0) ? qa.pop_front() : IDLE_E;
      cur_b = (qb.size() > 0) ? qb.pop_front() : IDLE_E;
    end
  end

  initial forever begin
    @(negedge clk);
    if (nRst === 1'b1) begin
      cmp("A.tx",     int'(bus_a.tx),     int'(cur_a.tx));
      cmp("A.prog",   int'(bus_a.prog),   int'(cur_a.prog));
      cmp("A.busy",   int'(bus_a.busy),   int'(cur_a.busy));
      cmp("A.done",   int'(bus_a.done),   int'(cur_a.done));
      cmp("A.mem_rd", int'(bus_a.mem_rd), int'(cur_a.rd));
      if (cur_a.rd) cmp("A.mem_addr", int'(bus_a.mem_addr), int'(cur_a.addr));
      cmp("B.tx",     int'(bus_b.tx),     int'(cur_b.tx));
      cmp("B.prog",   int'(bus_b.prog),   int'(cur_b.prog));
      cmp("B.busy",   int'(bus_b.busy),   int'(cur_b.busy));
      cmp("B.done",   int'(bus_b.done),   int'(cur_b.done));
      cmp("B.mem_rd", int'(bus_b.mem_rd), int'(cur_b.rd));
      if (cur_b.rd) cmp("B.mem_addr", int'(bus_b.mem_addr), int'(cur_b.addr));
    end
  end

  // Receiver + loader on line A: resets whenever prog is low, checks the sync
  // byte, then stores image bytes in arrival order.
  logic [7:0] rxq[$];
  logic       rx_act    = 1'b0;
  logic       rx_sync   = 1'b0;
  logic       prog_prev = 1'b0;
  logic [7:0] rx_sh     = 8'h00;
  int         rx_s      = 0;

  initial forever begin
    @(negedge clk);
    if (nRst !== 1'b1 || !bus_a.prog) begin
      rx_act  = 1'b0;
      rx_sync = 1'b0;
    end else begin
      if (!prog_prev) rxq.delete();
      if (!rx_act) begin
        if (!bus_a.tx) begin
          rx_act = 1'b1;
          rx_s   = 0;
        end
      end else begin
        rx_s++;
        if (rx_s % D == D / 2) begin
          if (rx_s / D >= 1 && rx_s / D <= 8) begin
            rx_sh[rx_s / D - 1] = bus_a.tx;
          end else if (rx_s / D == 9) begin
            rx_act = 1'b0;
            cmp("rx.stop", int'(bus_a.tx), 1);
            if (!rx_sync) begin
              cmp("rx.sync", int'(rx_sh), 8'h55);
              rx_sync = 1'b1;
            end else begin
              rxq.push_back(rx_sh);
            end
          end
        end
      end
    end
    prog_prev = (nRst === 1'b1) && bus_a.prog;
  end

  function automatic logic sig_rd(int which);
    return (which == 0) ? bus_a.mem_rd : bus_b.mem_rd;
  endfunction

  function automatic logic sig_done(int which);
    return (which == 0) ? bus_a.done : bus_b.done;
  endfunction

  task automatic kick(input int which, input int len);
    @(negedge clk);
    if (which == 0) begin bus_a.start = 1'b1; bus_a.length = 8'(len); end
    else            begin bus_b.start = 1'b1; bus_b.length = 8'(len); end
    @(negedge clk);
    if (which == 0) bus_a.start = 1'b0;
    else            bus_b.start = 1'b0;
  endtask

  // n counts cycles after the start edge; n=1 is the first busy cycle.
  task automatic wait_done(input int which, input int n0, input int maxn,
                           output int n_done, output int n_rd1, output int n_rds);
    int n;
    n      = n0;
    n_done = -1;
    n_rd1  = -1;
    n_rds  = 0;
    while (n <= maxn) begin
      if (sig_rd(which)) begin
        if (n_rd1 < 0) n_rd1 = n;
        n_rds++;
      end
      if (sig_done(which)) begin
        n_done = n;
        break;
      end
      @(negedge clk);
      n++;
    end
    if (n_done < 0) begin
      total++;
      bad++;
      $display("FAIL wait_done(%0d): no done within %0d cycles", which, maxn);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, r1, rc, errs;
    bus_a.start = 1'b0; bus_a.length = 8'd0;
    bus_b.start = 1'b0; bus_b.length = 8'd0;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    nRst = 1'b0;
    repeat (3) @(negedge clk);

    cmp("rst.A.tx",       int'(bus_a.tx),       1);
    cmp("rst.A.prog",     int'(bus_a.prog),     0);
    cmp("rst.A.busy",     int'(bus_a.busy),     0);
    cmp("rst.A.done",     int'(bus_a.done),     0);
    cmp("rst.A.mem_rd",   int'(bus_a.mem_rd),   0);
    cmp("rst.A.mem_addr", int'(bus_a.mem_addr), 0);
    cmp("rst.B.tx",       int'(bus_b.tx),       1);
    cmp("rst.B.busy",     int'(bus_b.busy),     0);
    nRst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic three-byte image with 2-bit gaps.
    mem[0] = 8'hA5; mem[1] = 8'h00; mem[2] = 8'hFF;
    kick(0, 3);
    cmp("t1.first_tx",   int'(bus_a.tx),   0);
    cmp("t1.first_prog", int'(bus_a.prog), 1);
    cmp("t1.first_busy", int'(bus_a.busy), 1);
    wait_done(0, 1, 400, nd, r1, rc);
    cmp("t1.done_cycle", nd, 199);
    cmp("t1.first_rd",   r1, 49);
    cmp("t1.rd_count",   rc, 3);
    cmp("t1.rx_count",   rxq.size(), 3);
    if (rxq.size() == 3) begin
      cmp("t1.rx0", int'(rxq[0]), 8'hA5);
      cmp("t1.rx1", int'(rxq[1]), 8'h00);
      cmp("t1.rx2", int'(rxq[2]), 8'hFF);
    end
    @(negedge clk);
    cmp("t1.done_gone", int'(bus_a.done), 0);
    cmp("t1.busy_gone", int'(bus_a.busy), 0);

    // length 0 streams all 256 bytes.
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
    kick(0, 0);
    wait_done(0, 1, 13000, nd, r1, rc);
    cmp("t2.done_cycle", nd, 12849);
    cmp("t2.rd_count",   rc, 256);
    cmp("t2.rx_count",   rxq.size(), 256);
    errs = 0;
    for (int i = 0; i < rxq.size(); i++) if (rxq[i] != 8'(i)) errs++;
    cmp("t2.rx_image_errs", errs, 0);
    if (rxq.size() == 256) cmp("t2.rx_last", int'(rxq[255]), 8'hFF);

    // start pulses during FRAME and GAP are ignored.
    repeat (3) @(negedge clk);
    mem[0] = 8'h12; mem[1] = 8'h34;
    kick(0, 2);
    repeat (9) @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    repeat (33) @(negedge clk);
    bus_a.start = 1'b1;
    @(negedge clk);
    bus_a.start = 1'b0;
    wait_done(0, 45, 400, nd, r1, rc);
    cmp("t3.done_cycle", nd, 149);
    cmp("t3.rd_count",   rc, 2);
    errs = 0;
    repeat (60) begin
      @(negedge clk);
      if (bus_a.done || bus_a.busy) errs++;
    end
    cmp("t3.extra_activity", errs, 0);

    // Zero gap: FETCH follows the stop bit directly.
    mem[0] = 8'h3C; mem[1] = 8'hC3;
    kick(1, 2);
    cmp("t4.first_tx", int'(bus_b.tx), 0);
    wait_done(1, 1, 300, nd, r1, rc);
    cmp("t4.done_cycle", nd, 125);
    cmp("t4.first_rd",   r1, 41);
    cmp("t4.rd_count",   rc, 2);

    // start held high restarts on the cycle after done.
    @(negedge clk);
    bus_b.start = 1'b1; bus_b.length = 8'd1;
    @(negedge clk);
    wait_done(1, 1, 300, nd, r1, rc);
    cmp("t5.done_cycle", nd, 83);
    @(negedge clk);
    bus_b.start = 1'b0;
    cmp("t5.b2b_busy", int'(bus_b.busy), 1);
    cmp("t5.b2b_tx",   int'(bus_b.tx),   0);
    wait_done(1, 1, 300, nd, r1, rc);
    cmp("t5.done_cycle2", nd, 83);

    // Asynchronous reset in the middle of image byte 1, then a clean rerun.
    repeat (3) @(negedge clk);
    mem[0] = 8'hA5; mem[1] = 8'h00; mem[2] = 8'hFF;
    kick(0, 3);
    repeat (129) @(negedge clk);
    #2 nRst = 1'b0;
    #1;
    cmp("t6.rst_tx",     int'(bus_a.tx),     1);
    cmp("t6.rst_prog",   int'(bus_a.prog),   0);
    cmp("t6.rst_busy",   int'(bus_a.busy),   0);
    cmp("t6.rst_done",   int'(bus_a.done),   0);
    cmp("t6.rst_mem_rd", int'(bus_a.mem_rd), 0);
    @(negedge clk);
    nRst = 1'b1;
    repeat (2) @(negedge clk);
    kick(0, 3);
    wait_done(0, 1, 400, nd, r1, rc);
    cmp("t6.done_cycle", nd, 199);
    cmp("t6.rx_count",   rxq.size(), 3);
    if (rxq.size() == 3) begin
      cmp("t6.rx0", int'(rxq[0]), 8'hA5);
      cmp("t6.rx1", int'(rxq[1]), 8'h00);
      cmp("t6.rx2", int'(rxq[2]), 8'hFF);
    end
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
